instr_decode: RTL and testbench
===============================

Name: instr_decode

Overview:
- Pipeline stage directly downstream of instruction fetch. Consumes the fetched instruction word and its next-PC, and owns the 32x32 register file.
- Produces the registered ID/EX bundle: operands, immediate, destination, control.
- Resolves branches and jumps in ID with a single architectural delay slot and drives the redirect pair back to fetch.
- Detects load-use and branch-operand hazards and inserts bubbles.

Parameters:
- DATA_W, 32, operand/register width (equals `INSTR_WIDTH`/`ADDR_WIDTH`).
- REG_ADDR_W, 5, register index width.

Ports:
- clk_87 in 1: clock.
- rst_87 in 1: asynchronous active-high reset.
- instr_87 in 32: instruction from fetch.
- npc_87 in 32: PC+4 of instr_87.
- wb_en_87 in 1: register write enable from WB.
- wb_addr_87 in 5: WB destination.
- wb_data_87 in 32: WB data.
- mem_reg_wr_87 in 1: EX/MEM instruction writes a register.
- mem_dst_87 in 5: EX/MEM destination.
- pc_87 out 32: redirect target to fetch (combinational).
- sel_87 out 1: redirect valid to fetch (combinational).
- stall_87 out 1: hold request; upstream re-presents the same instr_87/npc_87 next cycle (combinational).
- ex_rs_val_87 out 32, ex_rt_val_87 out 32: operands.
- ex_imm_87 out 32: extended immediate.
- ex_shamt_87 out 5: shift amount.
- ex_dst_87 out 5: destination register.
- ex_alu_op_87 out 4: ALU operation.
- ex_alu_src_87 out 1: 1 selects immediate.
- ex_mem_rd_87 out 1, ex_mem_wr_87 out 1, ex_reg_wr_87 out 1, ex_mem_to_reg_87 out 1: memory and writeback control.
- ex_npc_87 out 32: PC+4 passthrough.
- ill_87 out 1: registered illegal-opcode flag.

Behaviour:
- Reset: all ex_* outputs and ill_87 are 0, giving a NOP bubble. Register file is cleared to 0. pc_87, sel_87 and stall_87 are 0 while rst_87 is high. Reset mid-operation discards the ID/EX contents immediately.
- Latency: instr_87 presented in cycle N appears on ex_* after the rising edge ending cycle N.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, SLT, SLL, SRL, JR.
  - I-type: ADDIU, SLTI, ANDI, ORI, LUI, LW, SW, BEQ, BNE.
  - J-type: J.
  - Any other opcode/funct: bubble, ill_87=1 for one cycle.
  - 0x00000000 is a legal NOP (SLL r0).
- Immediate extension:
  - ANDI/ORI zero-extend.
  - LUI gives imm<<16.
  - All others sign-extend.
- Destination:
  - rd for R-type, rt for I-type.
  - ex_reg_wr_87 is forced to 0 when the destination is r0, and for SW/branches/J/JR.
- Register file:
  - r0 reads 0 and ignores writes.
  - Write occurs on the clock edge when wb_en_87=1.
  - Two combinational read ports addressed by rs and rt.
- Branch/jump:
  - BEQ/BNE compare read values. If taken: sel_87=1, pc_87 = npc_87 + (sext(imm)<<2).
  - J: pc_87 = {npc_87[31:28], target, 2'b00}.
  - JR: pc_87 = rs value.
  - Delay slot: the instruction after the branch always executes; there is no flush.
- Load-use hazard: stall when ex_mem_rd_87=1 and ex_dst_87 is nonzero and equals a source register the current instruction actually uses.
- Branch-operand hazard: BEQ/BNE/JR stall when a source register is nonzero and matches either:
  - ex_dst_87 with ex_reg_wr_87=1, or
  - mem_dst_87 with mem_reg_wr_87=1.
- On stall:
  - stall_87=1 and sel_87=0 (redirect suppressed).
  - ID/EX loads a bubble (all control 0); ill_87 is not asserted.
  - The re-presented instruction is decoded afresh next cycle.
- Simultaneous events: a stall takes priority over redirect. An illegal opcode never stalls and never redirects.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: a read whose address equals wb_addr_87 (nonzero) while wb_en_87=1 returns wb_data_87 in the same cycle (write-through).
- Undefined: no bypass. Instead, the same condition raises stall_87 for one cycle, and the value is read from the array after the write.

Decomposition:
- mips_defs.vh holds:
  - opcode/funct localparams;
  - ALU op encodings (4-bit: ADD, SUB, AND, OR, SLT, SLL, SRL, LUI);
  - register index width;
  - r0 constant.
- One sub-module: reg_file (2R/1W, async reset, r0 hardwired, bypass under WB_BYPASS_EN).
- Decode, hazard and branch logic stay in instr_decode.

Test Plan:
- Reset asserted mid-stream:
  - all ex_* outputs 0 asynchronously;
  - after release, reading r5 returns 0.
- WB writes r3=0x1234; next cycle ADDU r4,r3,r3 → ex_rs_val_87 = ex_rt_val_87 = 0x1234, ex_dst_87=4, ex_reg_wr_87=1, ex_alu_src_87=0.
- LW r2,4(r1) followed by ADDU r5,r2,r2:
  - stall_87=1 for exactly one cycle and a bubble is inserted;
  - the ADDU then issues.
- BEQ r1,r1,+3 with npc=0x100, no hazard → sel_87=1, pc_87=0x10C in the same cycle. A BNE with equal operands → sel_87=0.
- J 0x40 with npc=0x0000_0200 → pc_87=0x100. JR r7 (r7=0x80) → pc_87=0x80. Opcode 0x3F → ill_87=1 and a bubble.
- WB writes r6 while ADDU reads r6 in the same cycle:
  - with WB_BYPASS_EN, new value and no stall;
  - without it, one stall cycle, then the new value.

Source files
------------

// File: rtl/instr_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_pkg
//  Description : Shared MIPS-subset definitions for the decode stage:
//                opcode/funct codes, ALU operation encodings, immediate
//                extension kinds, register index width and the r0 constant.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_decode_pkg;

    // Register index width and the hardwired-zero register
    localparam int                   REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] R0        = 5'd0;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU operation encodings carried to EX
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_e;

    // How the 16-bit immediate field is widened
    typedef enum logic [1:0] {
        IMM_SEXT = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_LUI  = 2'd2
    } imm_kind_e;

endpackage : instr_decode_pkg
`default_nettype wire

// File: rtl/instr_decode_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : 32-entry register file, two combinational read ports and
//                one clocked write port. r0 always reads zero and ignores
//                writes. Contents clear on asynchronous reset.
//                With WB_BYPASS_EN defined, a read of the register being
//                written this cycle returns the write data (write-through).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import instr_decode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = REG_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b
);

    localparam int DEPTH = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Array storage: cleared on reset, r0 is never written so it stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port A, with optional same-cycle write-through
    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a != '0) begin
            rd_data_a = regs[rd_addr_a];
`ifdef WB_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr_a)) begin
                rd_data_a = wr_data;
            end
`endif
        end
    end

    // Read port B, with optional same-cycle write-through
    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b != '0) begin
            rd_data_b = regs[rd_addr_b];
`ifdef WB_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr_b)) begin
                rd_data_b = wr_data;
            end
`endif
        end
    end

endmodule : reg_file
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode
//  Description : MIPS-subset ID stage. Decodes the fetched word, reads the
//                register file, resolves branches/jumps (one delay slot, no
//                flush), detects load-use and branch-operand hazards and
//                registers the ID/EX bundle.
//                Optional macro WB_BYPASS_EN: WB write-through on register
//                reads; when undefined, a WB/read collision stalls one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = REG_IDX_W
) (
    input  logic                  clk_87,
    input  logic                  rst_87,
    input  logic [31:0]           instr_87,
    input  logic [DATA_W-1:0]     npc_87,
    input  logic                  wb_en_87,
    input  logic [REG_ADDR_W-1:0] wb_addr_87,
    input  logic [DATA_W-1:0]     wb_data_87,
    input  logic                  mem_reg_wr_87,
    input  logic [REG_ADDR_W-1:0] mem_dst_87,
    output logic [DATA_W-1:0]     pc_87,
    output logic                  sel_87,
    output logic                  stall_87,
    output logic [DATA_W-1:0]     ex_rs_val_87,
    output logic [DATA_W-1:0]     ex_rt_val_87,
    output logic [DATA_W-1:0]     ex_imm_87,
    output logic [4:0]            ex_shamt_87,
    output logic [REG_ADDR_W-1:0] ex_dst_87,
    output logic [3:0]            ex_alu_op_87,
    output logic                  ex_alu_src_87,
    output logic                  ex_mem_rd_87,
    output logic                  ex_mem_wr_87,
    output logic                  ex_reg_wr_87,
    output logic                  ex_mem_to_reg_87,
    output logic [DATA_W-1:0]     ex_npc_87,
    output logic                  ill_87
);

    // Instruction fields
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [4:0]            shamt;
    logic [15:0]           imm16;
    logic [25:0]           target;

    assign opcode = instr_87[31:26];
    assign rs     = instr_87[25:21];
    assign rt     = instr_87[20:16];
    assign rd     = instr_87[15:11];
    assign shamt  = instr_87[10:6];
    assign funct  = instr_87[5:0];
    assign imm16  = instr_87[15:0];
    assign target = instr_87[25:0];

    // Decoded controls
    logic                  legal;
    logic                  uses_rs;
    logic                  uses_rt;
    logic                  is_beq;
    logic                  is_bne;
    logic                  is_j;
    logic                  is_jr;
    alu_op_e               alu_op;
    imm_kind_e             imm_kind;
    logic                  alu_src;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  reg_wr;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     imm_ext;
    logic [DATA_W-1:0]     imm_sext;

    // Register file read data
    logic [DATA_W-1:0]     rs_val;
    logic [DATA_W-1:0]     rt_val;

    // Branch / hazard terms
    logic                  taken;
    logic [DATA_W-1:0]     redirect_pc;
    logic                  load_use;
    logic                  branch_haz;
    logic                  wb_haz;
    logic                  stall_req;

    reg_file #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_reg_file (
        .clk       (clk_87),
        .rst       (rst_87),
        .wr_en     (wb_en_87),
        .wr_addr   (wb_addr_87),
        .wr_data   (wb_data_87),
        .rd_addr_a (rs),
        .rd_data_a (rs_val),
        .rd_addr_b (rt),
        .rd_data_b (rt_val)
    );

    // Opcode/funct decode into control bits and source-usage flags
    always_comb begin
        legal      = 1'b0;
        uses_rs    = 1'b0;
        uses_rt    = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_jr      = 1'b0;
        alu_op     = ALU_ADD;
        imm_kind   = IMM_SEXT;
        alu_src    = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        mem_to_reg = 1'b0;
        dst        = rt;
        case (opcode)
            OP_RTYPE: begin
                dst = rd;
                case (funct)
                    FN_ADDU: begin legal = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; alu_op = ALU_ADD; reg_wr = 1'b1; end
                    FN_SUBU: begin legal = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; alu_op = ALU_SUB; reg_wr = 1'b1; end
                    FN_AND:  begin legal = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; alu_op = ALU_AND; reg_wr = 1'b1; end
                    FN_OR:   begin legal = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; alu_op = ALU_OR;  reg_wr = 1'b1; end
                    FN_SLT:  begin legal = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; alu_op = ALU_SLT; reg_wr = 1'b1; end
                    FN_SLL:  begin legal = 1'b1; uses_rt = 1'b1; alu_op = ALU_SLL; reg_wr = 1'b1; end
                    FN_SRL:  begin legal = 1'b1; uses_rt = 1'b1; alu_op = ALU_SRL; reg_wr = 1'b1; end
                    FN_JR:   begin legal = 1'b1; uses_rs = 1'b1; is_jr = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDIU: begin legal = 1'b1; uses_rs = 1'b1; alu_op = ALU_ADD; alu_src = 1'b1; reg_wr = 1'b1; end
            OP_SLTI:  begin legal = 1'b1; uses_rs = 1'b1; alu_op = ALU_SLT; alu_src = 1'b1; reg_wr = 1'b1; end
            OP_ANDI:  begin legal = 1'b1; uses_rs = 1'b1; alu_op = ALU_AND; alu_src = 1'b1; reg_wr = 1'b1; imm_kind = IMM_ZEXT; end
            OP_ORI:   begin legal = 1'b1; uses_rs = 1'b1; alu_op = ALU_OR;  alu_src = 1'b1; reg_wr = 1'b1; imm_kind = IMM_ZEXT; end
            OP_LUI:   begin legal = 1'b1; alu_op = ALU_LUI; alu_src = 1'b1; reg_wr = 1'b1; imm_kind = IMM_LUI; end
            OP_LW: begin
                legal = 1'b1; uses_rs = 1'b1; alu_op = ALU_ADD; alu_src = 1'b1;
                mem_rd = 1'b1; reg_wr = 1'b1; mem_to_reg = 1'b1;
            end
            OP_SW:  begin legal = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; alu_op = ALU_ADD; alu_src = 1'b1; mem_wr = 1'b1; end
            OP_BEQ: begin legal = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; alu_op = ALU_SUB; is_beq = 1'b1; end
            OP_BNE: begin legal = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; alu_op = ALU_SUB; is_bne = 1'b1; end
            OP_J:   begin legal = 1'b1; is_j = 1'b1; end
            default: legal = 1'b0;
        endcase
        // Writes to r0 are architecturally discarded; drop them here so
        // downstream hazard/forwarding logic never sees them.
        if (dst == R0) begin
            reg_wr = 1'b0;
        end
    end

    assign imm_sext = {{(DATA_W-16){imm16[15]}}, imm16};

    // Immediate widening
    always_comb begin
        imm_ext = imm_sext;
        case (imm_kind)
            IMM_ZEXT: imm_ext = {{(DATA_W-16){1'b0}}, imm16};
            IMM_LUI:  imm_ext = {imm16, {(DATA_W-16){1'b0}}};
            default:  imm_ext = imm_sext;
        endcase
    end

    // Branch/jump resolution and redirect target selection
    always_comb begin
        taken       = 1'b0;
        redirect_pc = '0;
        if (is_beq || is_bne) begin
            taken       = is_beq ? (rs_val == rt_val) : (rs_val != rt_val);
            redirect_pc = npc_87 + {imm_sext[DATA_W-3:0], 2'b00};
        end else if (is_j) begin
            taken       = 1'b1;
            redirect_pc = {npc_87[DATA_W-1:DATA_W-4], target, 2'b00};
        end else if (is_jr) begin
            taken       = 1'b1;
            redirect_pc = rs_val;
        end
    end

    // Hazard detection; only sources the instruction actually consumes count
    always_comb begin
        load_use = ex_mem_rd_87 && (ex_dst_87 != R0) &&
                   ((uses_rs && (rs == ex_dst_87)) || (uses_rt && (rt == ex_dst_87)));

        branch_haz = (is_beq || is_bne || is_jr) && (
            (uses_rs && (rs != R0) &&
             ((ex_reg_wr_87 && (rs == ex_dst_87)) || (mem_reg_wr_87 && (rs == mem_dst_87)))) ||
            (uses_rt && (rt != R0) &&
             ((ex_reg_wr_87 && (rt == ex_dst_87)) || (mem_reg_wr_87 && (rt == mem_dst_87)))));

`ifdef WB_BYPASS_EN
        wb_haz = 1'b0;
`else
        // Without write-through, wait one cycle so the array holds the value
        wb_haz = wb_en_87 && (wb_addr_87 != R0) &&
                 ((uses_rs && (rs == wb_addr_87)) || (uses_rt && (rt == wb_addr_87)));
`endif

        // Illegal words become a bubble directly and never hold fetch
        stall_req = legal && (load_use || branch_haz || wb_haz);
    end

    assign stall_87 = !rst_87 && stall_req;
    assign sel_87   = !rst_87 && legal && !stall_req && taken;
    assign pc_87    = sel_87 ? redirect_pc : '0;

    // ID/EX pipeline register: bubble on stall or illegal, else the decode
    always_ff @(posedge clk_87 or posedge rst_87) begin
        if (rst_87) begin
            ex_rs_val_87     <= '0;
            ex_rt_val_87     <= '0;
            ex_imm_87        <= '0;
            ex_shamt_87      <= '0;
            ex_dst_87        <= '0;
            ex_alu_op_87     <= '0;
            ex_alu_src_87    <= 1'b0;
            ex_mem_rd_87     <= 1'b0;
            ex_mem_wr_87     <= 1'b0;
            ex_reg_wr_87     <= 1'b0;
            ex_mem_to_reg_87 <= 1'b0;
            ex_npc_87        <= '0;
            ill_87           <= 1'b0;
        end else if (!legal || stall_req) begin
            ex_rs_val_87     <= '0;
            ex_rt_val_87     <= '0;
            ex_imm_87        <= '0;
            ex_shamt_87      <= '0;
            ex_dst_87        <= '0;
            ex_alu_op_87     <= '0;
            ex_alu_src_87    <= 1'b0;
            ex_mem_rd_87     <= 1'b0;
            ex_mem_wr_87     <= 1'b0;
            ex_reg_wr_87     <= 1'b0;
            ex_mem_to_reg_87 <= 1'b0;
            ex_npc_87        <= '0;
            ill_87           <= !legal;
        end else begin
            ex_rs_val_87     <= rs_val;
            ex_rt_val_87     <= rt_val;
            ex_imm_87        <= imm_ext;
            ex_shamt_87      <= shamt;
            ex_dst_87        <= dst;
            ex_alu_op_87     <= alu_op;
            ex_alu_src_87    <= alu_src;
            ex_mem_rd_87     <= mem_rd;
            ex_mem_wr_87     <= mem_wr;
            ex_reg_wr_87     <= reg_wr;
            ex_mem_to_reg_87 <= mem_to_reg;
            ex_npc_87        <= npc_87;
            ill_87           <= 1'b0;
        end
    end

endmodule : instr_decode
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_decode
//  Description : Scoreboard bench for instr_decode. The driver pushes the
//                hand-computed expectation for each presented instruction;
//                a monitor pops it, checks the combinational redirect/stall
//                outputs before the edge and the ID/EX bundle after it.
//                Follows WB_BYPASS_EN to pick the expected WB-collision case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] npc = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        mem_reg_wr = 1'b0;
    logic [4:0]  mem_dst = '0;

    logic [31:0] pc, rs_val, rt_val, imm, ex_npc;
    logic        sel, stall, alu_src, mem_rd, mem_wr, reg_wr, mem_to_reg, ill;
    logic [4:0]  shamt, dst;
    logic [3:0]  alu_op;

    instr_decode dut (
        .clk_87           (clk),
        .rst_87           (rst),
        .instr_87         (instr),
        .npc_87           (npc),
        .wb_en_87         (wb_en),
        .wb_addr_87       (wb_addr),
        .wb_data_87       (wb_data),
        .mem_reg_wr_87    (mem_reg_wr),
        .mem_dst_87       (mem_dst),
        .pc_87            (pc),
        .sel_87           (sel),
        .stall_87         (stall),
        .ex_rs_val_87     (rs_val),
        .ex_rt_val_87     (rt_val),
        .ex_imm_87        (imm),
        .ex_shamt_87      (shamt),
        .ex_dst_87        (dst),
        .ex_alu_op_87     (alu_op),
        .ex_alu_src_87    (alu_src),
        .ex_mem_rd_87     (mem_rd),
        .ex_mem_wr_87     (mem_wr),
        .ex_reg_wr_87     (reg_wr),
        .ex_mem_to_reg_87 (mem_to_reg),
        .ex_npc_87        (ex_npc),
        .ill_87           (ill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] name;
        logic        stall;
        logic        sel;
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] npc;
        logic [4:0]  shamt;
        logic [4:0]  dst;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        mem_to_reg;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input logic [95:0] nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s.%0s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    function automatic exp_t bub(input logic [95:0] nm, input logic stl);
        exp_t e;
        e.name = nm; e.stall = stl; e.sel = 1'b0; e.pc = '0;
        e.rs_val = '0; e.rt_val = '0; e.imm = '0; e.npc = '0;
        e.shamt = '0; e.dst = '0; e.alu_op = '0; e.alu_src = 1'b0;
        e.mem_rd = 1'b0; e.mem_wr = 1'b0; e.reg_wr = 1'b0;
        e.mem_to_reg = 1'b0; e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t dec(input logic [95:0] nm,
                                 input logic [31:0] rsv, input logic [31:0] rtv,
                                 input logic [31:0] im, input logic [31:0] np,
                                 input logic [4:0] sh, input logic [4:0] d,
                                 input logic [3:0] op, input logic src,
                                 input logic mrd, input logic mwr,
                                 input logic rwr, input logic m2r);
        exp_t e;
        e = bub(nm, 1'b0);
        e.rs_val = rsv; e.rt_val = rtv; e.imm = im; e.npc = np;
        e.shamt = sh; e.dst = d; e.alu_op = op; e.alu_src = src;
        e.mem_rd = mrd; e.mem_wr = mwr; e.reg_wr = rwr; e.mem_to_reg = m2r;
        return e;
    endfunction

    // One stimulus cycle: drive at the falling edge and log the expectation
    task automatic cyc(input logic [31:0] ins, input logic [31:0] np,
                       input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic mrw, input logic [4:0] md, input exp_t e);
        @(negedge clk);
        instr = ins; npc = np;
        wb_en = wbe; wb_addr = wba; wb_data = wbd;
        mem_reg_wr = mrw; mem_dst = md;
        q.push_back(e);
    endtask

    // Monitor: combinational outputs before the edge, ID/EX after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "stall", {31'd0, stall}, {31'd0, e.stall});
                chk(e.name, "sel",   {31'd0, sel},   {31'd0, e.sel});
                chk(e.name, "pc",    pc,             e.pc);
                @(posedge clk);
                #1;
                chk(e.name, "rs_val",  rs_val,  e.rs_val);
                chk(e.name, "rt_val",  rt_val,  e.rt_val);
                chk(e.name, "imm",     imm,     e.imm);
                chk(e.name, "npc",     ex_npc,  e.npc);
                chk(e.name, "shamt",   {27'd0, shamt},  {27'd0, e.shamt});
                chk(e.name, "dst",     {27'd0, dst},    {27'd0, e.dst});
                chk(e.name, "alu_op",  {28'd0, alu_op}, {28'd0, e.alu_op});
                chk(e.name, "alu_src", {31'd0, alu_src},    {31'd0, e.alu_src});
                chk(e.name, "mem_rd",  {31'd0, mem_rd},     {31'd0, e.mem_rd});
                chk(e.name, "mem_wr",  {31'd0, mem_wr},     {31'd0, e.mem_wr});
                chk(e.name, "reg_wr",  {31'd0, reg_wr},     {31'd0, e.reg_wr});
                chk(e.name, "mem2reg", {31'd0, mem_to_reg}, {31'd0, e.mem_to_reg});
                chk(e.name, "ill",     {31'd0, ill},        {31'd0, e.ill});
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        exp_t e;
        // Power-on reset
        #1 rst = 1'b1;
        #2;
        chk("por", "reg_wr", {31'd0, reg_wr}, 32'd0);
        chk("por", "alu_op", {28'd0, alu_op}, 32'd0);
        chk("por", "ill",    {31'd0, ill},    32'd0);
        chk("por", "sel",    {31'd0, sel},    32'd0);
        chk("por", "stall",  {31'd0, stall},  32'd0);
        chk("por", "pc",     pc,              32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load registers through WB while issuing NOPs
        cyc(32'h0000_0000, 32'h10, 1'b1, 5'd3, 32'h1234, 1'b0, 5'd0,
            dec("nop", 0, 0, 0, 32'h10, 0, 0, 4'd5, 0, 0, 0, 0, 0));
        cyc(32'h0000_0000, 32'h14, 1'b1, 5'd1, 32'h55, 1'b0, 5'd0,
            dec("nop", 0, 0, 0, 32'h14, 0, 0, 4'd5, 0, 0, 0, 0, 0));
        cyc(32'h0000_0000, 32'h18, 1'b1, 5'd7, 32'h80, 1'b0, 5'd0,
            dec("nop", 0, 0, 0, 32'h18, 0, 0, 4'd5, 0, 0, 0, 0, 0));

        // ADDU r4,r3,r3
        cyc(32'h0063_2021, 32'h1C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("addu", 32'h1234, 32'h1234, 32'h2021, 32'h1C, 0, 5'd4, 4'd0, 0, 0, 0, 1, 0));

        // LW r2,4(r1) then ADDU r5,r2,r2: one stall, then issue
        cyc(32'h8C22_0004, 32'h20, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("lw", 32'h55, 0, 32'h4, 32'h20, 0, 5'd2, 4'd0, 1, 1, 0, 1, 1));
        cyc(32'h0042_2821, 32'h24, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, bub("lu_stall", 1'b1));
        cyc(32'h0042_2821, 32'h24, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("lu_issue", 0, 0, 32'h2821, 32'h24, 0, 5'd5, 4'd0, 0, 0, 0, 1, 0));

        // BEQ r1,r1,+3 taken; BNE r1,r1,+3 not taken
        e = dec("beq", 32'h55, 32'h55, 32'h3, 32'h100, 0, 5'd1, 4'd1, 0, 0, 0, 0, 0);
        e.sel = 1'b1; e.pc = 32'h10C;
        cyc(32'h1021_0003, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, e);
        cyc(32'h1421_0003, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("bne", 32'h55, 32'h55, 32'h3, 32'h104, 0, 5'd1, 4'd1, 0, 0, 0, 0, 0));

        // J 0x40 and JR r7
        e = dec("j", 0, 0, 32'h40, 32'h200, 5'd1, 5'd0, 4'd0, 0, 0, 0, 0, 0);
        e.sel = 1'b1; e.pc = 32'h100;
        cyc(32'h0800_0040, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, e);
        e = dec("jr", 32'h80, 0, 32'h8, 32'h208, 0, 5'd0, 4'd0, 0, 0, 0, 0, 0);
        e.sel = 1'b1; e.pc = 32'h80;
        cyc(32'h00E0_0008, 32'h208, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, e);

        // Illegal opcode 0x3F
        e = bub("ill", 1'b0);
        e.ill = 1'b1;
        cyc(32'hFC00_0000, 32'h20C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, e);

        // NOP clears ill; also writes r5 for the reset test later
        cyc(32'h0000_0000, 32'h210, 1'b1, 5'd5, 32'h77, 1'b0, 5'd0,
            dec("nop_r5", 0, 0, 0, 32'h210, 0, 0, 4'd5, 0, 0, 0, 0, 0));

        // Branch-operand hazard against EX/MEM destination
        cyc(32'h1021_0003, 32'h300, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, bub("br_haz", 1'b1));
        e = dec("beq2", 32'h55, 32'h55, 32'h3, 32'h300, 0, 5'd1, 4'd1, 0, 0, 0, 0, 0);
        e.sel = 1'b1; e.pc = 32'h30C;
        cyc(32'h1021_0003, 32'h300, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, e);

        // WB writes r6 while ADDU r8,r6,r6 reads it
`ifdef WB_BYPASS_EN
        cyc(32'h00C6_4021, 32'h400, 1'b1, 5'd6, 32'hABCD, 1'b0, 5'd0,
            dec("wb_byp", 32'hABCD, 32'hABCD, 32'h4021, 32'h400, 0, 5'd8, 4'd0, 0, 0, 0, 1, 0));
`else
        cyc(32'h00C6_4021, 32'h400, 1'b1, 5'd6, 32'hABCD, 1'b0, 5'd0, bub("wb_stall", 1'b1));
        cyc(32'h00C6_4021, 32'h400, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("wb_after", 32'hABCD, 32'hABCD, 32'h4021, 32'h400, 0, 5'd8, 4'd0, 0, 0, 0, 1, 0));
`endif

        // Remaining formats and immediate extensions
        cyc(32'h0003_4900, 32'h404, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("sll", 0, 32'h1234, 32'h4900, 32'h404, 5'd4, 5'd9, 4'd5, 0, 0, 0, 1, 0));
        cyc(32'h346A_8001, 32'h408, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("ori", 32'h1234, 0, 32'h0000_8001, 32'h408, 0, 5'd10, 4'd3, 1, 0, 0, 1, 0));
        cyc(32'h246B_FFFF, 32'h40C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("addiu", 32'h1234, 0, 32'hFFFF_FFFF, 32'h40C, 5'd31, 5'd11, 4'd0, 1, 0, 0, 1, 0));
        cyc(32'h3C0C_1234, 32'h410, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("lui", 0, 0, 32'h1234_0000, 32'h410, 5'd8, 5'd12, 4'd7, 1, 0, 0, 1, 0));
        cyc(32'hAC23_0008, 32'h414, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("sw", 32'h55, 32'h1234, 32'h8, 32'h414, 0, 5'd3, 4'd0, 1, 0, 1, 0, 0));
        cyc(32'h0063_0021, 32'h418, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("addu_r0", 32'h1234, 32'h1234, 32'h21, 32'h418, 0, 5'd0, 4'd0, 0, 0, 0, 0, 0));

        // Let the scoreboard drain, then reset asynchronously mid-cycle
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid", "rs_val", rs_val, 32'd0);
        chk("rst_mid", "imm",    imm,    32'd0);
        chk("rst_mid", "npc",    ex_npc, 32'd0);
        chk("rst_mid", "stall",  {31'd0, stall}, 32'd0);
        chk("rst_mid", "sel",    {31'd0, sel},   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Register file cleared: r5 reads 0
        cyc(32'h00A5_6821, 32'h500, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
            dec("rst_r5", 0, 0, 32'h6821, 32'h500, 0, 5'd13, 4'd0, 0, 0, 0, 1, 0));

        repeat (3) @(negedge clk);
        chk("drain", "qsize", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_decode
`default_nettype wire
